// File: rtl/image_mem_stream_reader.sv
// Read-side sequencer for the 16-lane complex image memory: turns (base, length, stride)
// bursts into block read addresses and re-times the returned words into a valid/ready stream.
module image_mem_stream_reader #(
  parameter int ADDR_WIDTH = 13,
  parameter int LANES      = 16,
  parameter int LANE_WIDTH = 64,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_cmd_valid,
  output logic                        o_cmd_ready,
  input  logic [ADDR_WIDTH-1:0]       i_cmd_base_addr,
  input  logic [ADDR_WIDTH:0]         i_cmd_len,
  input  logic [ADDR_WIDTH-1:0]       i_cmd_stride,
  output logic [ADDR_WIDTH-1:0]       o_mem_read_address,
  input  logic [LANES*LANE_WIDTH-1:0] i_mem_data_out,
  output logic                        o_out_valid,
  input  logic                        i_out_ready,
  output logic [LANES*LANE_WIDTH-1:0] o_out_data,
  output logic                        o_out_last,
  output logic                        o_busy,
  output logic                        o_done
);

  localparam int WORD_W = LANES * LANE_WIDTH;
  localparam int PTR_W  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W  = $clog2(BUF_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_stride;
  logic [ADDR_WIDTH:0]   r_remaining;
  logic                  r_inflight;
  logic                  r_inflightLast;
  logic [WORD_W-1:0]     r_bufData [BUF_DEPTH];
  logic [BUF_DEPTH-1:0]  r_bufLast;
  logic [PTR_W-1:0]      r_rdPtr;
  logic [PTR_W-1:0]      r_wrPtr;
  logic [CNT_W-1:0]      r_count;

  logic                  w_accept;
  logic                  w_pop;
  logic                  w_issue;
  logic [CNT_W:0]        w_projected;

  function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Occupancy after this edge counting the word already in flight; issuing only while
  // that stays below BUF_DEPTH is what keeps the capture from ever overflowing.
  always_comb begin
    w_accept    = (r_state == ST_IDLE) && i_cmd_valid;
    w_pop       = (r_count != '0) && i_out_ready;
    w_projected = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight} - {{CNT_W{1'b0}}, w_pop};
    w_issue     = (r_state == ST_ISSUE) && (r_remaining != '0) &&
                  (w_projected < (CNT_W+1)'(BUF_DEPTH));
  end

  always_comb begin
    w_nextState = r_state;
    o_cmd_ready = 1'b0;
    o_busy      = 1'b1;
    o_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_cmd_ready = 1'b1;
        o_busy      = 1'b0;
        if (w_accept) begin
          w_nextState = (i_cmd_len == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (r_remaining == '0) begin
          w_nextState = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_projected == '0) begin
          w_nextState = ST_DONE;
        end
      end
      ST_DONE: begin
        o_done      = 1'b1;
        w_nextState = ST_IDLE;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_addr         <= '0;
      r_stride       <= '0;
      r_remaining    <= '0;
      r_inflight     <= 1'b0;
      r_inflightLast <= 1'b0;
    end else begin
      r_state        <= w_nextState;
      r_inflight     <= w_issue;
      r_inflightLast <= w_issue && (r_remaining == (ADDR_WIDTH+1)'(1));
      if (w_accept && (i_cmd_len != '0)) begin
        r_addr      <= i_cmd_base_addr;
        r_remaining <= i_cmd_len;
        r_stride    <= i_cmd_stride;
      end else if (w_issue) begin
        r_addr      <= r_addr + r_stride;
        r_remaining <= r_remaining - 1'b1;
      end
    end
  end

  // Skid buffer bookkeeping: the capture one cycle after an issue is the only push source.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (r_inflight) begin
        r_wrPtr <= ptrInc(r_wrPtr);
      end
      if (w_pop) begin
        r_rdPtr <= ptrInc(r_rdPtr);
      end
      r_count <= r_count + CNT_W'(r_inflight) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (r_inflight) begin
      r_bufData[r_wrPtr] <= i_mem_data_out;
      r_bufLast[r_wrPtr] <= r_inflightLast;
    end
  end

  always_comb begin
    o_mem_read_address = r_addr;
    o_out_valid        = (r_count != '0);
    o_out_data         = o_out_valid ? r_bufData[r_rdPtr] : '0;
    o_out_last         = o_out_valid && r_bufLast[r_rdPtr];
  end

endmodule
